// File: rtl/convolutor_pkg.sv
// Shared types and constants for the convolution coprocessor result path.
package convolutor_pkg;

    localparam int CONV_ZDATA_W = 16;
    localparam int CONV_ZADDR_W = 6;

    typedef enum logic [1:0] {
        ZS_IDLE,
        ZS_FETCH,
        ZS_DRAIN
    } zs_state_t;

    typedef logic [CONV_ZDATA_W-1:0] zword_t;

endpackage

// File: rtl/convolutor_stream_fifo.sv
// Small synchronous first-word-fall-through FIFO that buffers {last, data}
// between the Z RAM read pipeline and the stream consumer.
module convolutor_stream_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage array write port.
    // NOTE: the data array has no reset; only pointers/count need one, and
    // the top gates the output while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The upstream credit scheme must never push into a full buffer.
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/convolutor_z_streamer.sv
// Reads words 0..len-1 from the Z RAM (1-clk registered read) and streams
// them over valid/ready with a last flag at up to one word per clock.
module convolutor_z_streamer
    import convolutor_pkg::*;
#(
    parameter int DATA_WIDTH = CONV_ZDATA_W,
    parameter int ADDR_WIDTH = CONV_ZADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   z_len_i,
    output logic [ADDR_WIDTH-1:0] zmem_addr_o,
    input  logic [DATA_WIDTH-1:0] zmem_data_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_WIDTH);

    zs_state_t        state;
    zs_state_t        state_nxt;

    logic [LEN_W-1:0] len_sat;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issue_cnt;   // reads issued so far
    logic [LEN_W-1:0] out_idx;     // words handed to the consumer so far
    logic [LEN_W-1:0] issue_idx;

    logic             rd_v1, rd_l1; // address on the RAM port this clk
    logic             rd_v2, rd_l2; // RAM data valid this clk

    logic             accept;
    logic             issue;
    logic             issue_last;
    logic             pop;
    logic             pop_last;
    logic             credit_ok;
    logic [CNT_W:0]   occupancy;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DATA_WIDTH:0] fifo_dout;

    assign len_sat   = (z_len_i > MAX_LEN) ? MAX_LEN : z_len_i;
    assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(rd_v1) + (CNT_W+1)'(rd_v2);
    assign credit_ok = ~fifo_full && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign pop       = m_valid_o & m_ready_i;
    assign pop_last  = pop && (out_idx == len_q - LEN_W'(1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ZS_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state: leave IDLE on a non-empty start, drain after the last read issue.
    // NOTE: every combinational output is defaulted first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ZS_IDLE:  if (issue)      state_nxt = issue_last ? ZS_DRAIN : ZS_FETCH;
            ZS_FETCH: if (issue_last) state_nxt = ZS_DRAIN;
            ZS_DRAIN: if (pop_last)   state_nxt = ZS_IDLE;
            default:                  state_nxt = ZS_IDLE;
        endcase
    end

    // FSM outputs: start acceptance and read issue under the buffer credit limit.
    always_comb begin
        accept     = 1'b0;
        issue      = 1'b0;
        issue_idx  = issue_cnt;
        issue_last = 1'b0;
        case (state)
            ZS_IDLE: begin
                accept     = start_i;
                issue      = start_i && (len_sat != '0);
                issue_idx  = '0;
                issue_last = issue && (len_sat == LEN_W'(1));
            end
            ZS_FETCH: begin
                issue      = credit_ok;
                issue_last = credit_ok && (issue_cnt == len_q - LEN_W'(1));
            end
            default: ;
        endcase
    end

    // Counters, read-pipeline flags, RAM address and the busy/done status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            issue_cnt   <= '0;
            out_idx     <= '0;
            zmem_addr_o <= '0;
            rd_v1       <= 1'b0;
            rd_l1       <= 1'b0;
            rd_v2       <= 1'b0;
            rd_l2       <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            rd_v1  <= issue;
            rd_l1  <= issue_last;
            rd_v2  <= rd_v1;
            rd_l2  <= rd_l1;
            done_o <= (accept && (len_sat == '0)) || pop_last;

            if (issue) zmem_addr_o <= issue_idx[ADDR_WIDTH-1:0];

            if (accept) begin
                len_q     <= len_sat;
                issue_cnt <= LEN_W'(issue);
                out_idx   <= '0;
                busy_o    <= (len_sat != '0);
            end else begin
                if (issue)    issue_cnt <= issue_cnt + LEN_W'(1);
                if (pop)      out_idx   <= out_idx + LEN_W'(1);
                if (pop_last) busy_o    <= 1'b0;
            end
        end
    end

    convolutor_stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_v2),
        .pop   (pop),
        .din   ({rd_l2, zmem_data_i}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_valid_o = ~fifo_empty;
    assign m_data_o  = fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
    assign m_last_o  = ~fifo_empty & fifo_dout[DATA_WIDTH];

endmodule
